// File: rtl/booth8_pkg.sv
// Shared types and constants for the iterative radix-8 Booth mantissa multiplier.
package booth8_pkg;

  localparam int MANT_W      = 11;
  localparam int PROD_W      = 2 * MANT_W;
  // Four guard bits hold the signed partial sums without wrapping.
  localparam int ACC_W       = PROD_W + 4;
  localparam int BF16_MANT_W = 8;

  localparam int FP16_DIGITS = 4;
  localparam int BF16_DIGITS = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Radix-8 Booth digit, value range -4..+4.
  typedef logic signed [3:0] booth_digit_t;

  // Window is {b[3i+2], b[3i+1], b[3i], b[3i-1]}; value = -4*w3 + 2*w2 + w1 + w0.
  function automatic booth_digit_t booth_digit(input logic [3:0] win);
    booth_digit_t d;
    d = 4'sd0 - (win[3] ? 4'sd4 : 4'sd0)
              + (win[2] ? 4'sd2 : 4'sd0)
              + (win[1] ? 4'sd1 : 4'sd0)
              + (win[0] ? 4'sd1 : 4'sd0);
    return d;
  endfunction

endpackage

// File: rtl/booth8_digit_select.sv
// Decodes one radix-8 Booth window and returns the matching multiple of A
// (0, +-A, +-2A, +-3A, +-4A) as a sign-extended two's-complement value.
module booth8_digit_select #(
  parameter int MANT_W = booth8_pkg::MANT_W,
  parameter int ACC_W  = booth8_pkg::ACC_W
) (
  input  logic [3:0]              win,
  input  logic [MANT_W-1:0]       a,
  output logic signed [ACC_W-1:0] mult
);
  import booth8_pkg::booth_digit_t;
  import booth8_pkg::booth_digit;

  booth_digit_t      digit;
  logic [2:0]        digit_abs;
  logic [MANT_W+1:0] a1;
  logic [MANT_W+1:0] a2;
  logic [MANT_W+1:0] a3;
  logic [MANT_W+1:0] a4;
  logic [ACC_W-1:0]  mag;

  assign digit     = booth_digit(win);
  assign digit_abs = digit[3] ? 3'(-digit) : 3'(digit);

  // Unsigned multiples fit in MANT_W+2 bits; 3A is the only one needing an adder.
  assign a1 = {2'b00, a};
  assign a2 = {1'b0, a, 1'b0};
  assign a3 = a1 + a2;
  assign a4 = {a, 2'b00};

  // Pick the magnitude, zero-extended to accumulator width.
  always_comb begin
    mag = '0;
    case (digit_abs)
      3'd1:    mag = ACC_W'(a1);
      3'd2:    mag = ACC_W'(a2);
      3'd3:    mag = ACC_W'(a3);
      3'd4:    mag = ACC_W'(a4);
      default: mag = '0;
    endcase
  end

  // Negative digits use invert-plus-one negation of the full-width magnitude.
  assign mult = digit[3] ? signed'(~mag + ACC_W'(1)) : signed'(mag);

endmodule

// File: rtl/booth8_iter_multiplier.sv
// Iterative radix-8 Booth multiplier: accepts one unsigned mantissa pair,
// adds one shifted Booth multiple per cycle and offers the product on a
// valid/ready output. BF16 mode uses only the low 8 bits and three digits.
module booth8_iter_multiplier #(
  parameter int MANT_W = booth8_pkg::MANT_W,
  parameter int PROD_W = booth8_pkg::PROD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] mant_a,
  input  logic [MANT_W-1:0] mant_b,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product
);
  import booth8_pkg::state_t;
  import booth8_pkg::IDLE;
  import booth8_pkg::RUN;
  import booth8_pkg::DONE;
  import booth8_pkg::FP16_DIGITS;
  import booth8_pkg::BF16_DIGITS;
  import booth8_pkg::BF16_MANT_W;

  localparam int         ACC_W     = PROD_W + 4;
  localparam logic [1:0] LAST_FP16 = 2'(FP16_DIGITS - 1);
  localparam logic [1:0] LAST_BF16 = 2'(BF16_DIGITS - 1);

  state_t                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [MANT_W-1:0]       a_q, a_d;
  logic [MANT_W-1:0]       b_q, b_d;
  logic                    mode_q, mode_d;

  logic [MANT_W+1:0]       b_ext;
  logic [3:0]              win;
  logic signed [ACC_W-1:0] mult;
  logic signed [ACC_W-1:0] mult_sh;
  logic [1:0]              last_cnt;

  // Implicit zero below bit 0 and above the MSB keeps the top digit non-negative.
  assign b_ext    = {1'b0, b_q, 1'b0};
  assign win      = b_ext[3*cnt_q +: 4];
  assign mult_sh  = mult << (3*cnt_q);
  assign last_cnt = mode_q ? LAST_BF16 : LAST_FP16;

  booth8_digit_select #(
    .MANT_W(MANT_W),
    .ACC_W (ACC_W)
  ) u_digit_select (
    .win (win),
    .a   (a_q),
    .mult(mult)
  );

  assign in_ready  = !rst && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = acc_q[PROD_W-1:0];

  // Next-state logic: accept in IDLE, one digit per cycle in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = mode ? {{(MANT_W-BF16_MANT_W){1'b0}}, mant_a[BF16_MANT_W-1:0]} : mant_a;
          b_d     = mode ? {{(MANT_W-BF16_MANT_W){1'b0}}, mant_b[BF16_MANT_W-1:0]} : mant_b;
          mode_d  = mode;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + mult_sh;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == last_cnt) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset that aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_booth8_iter_multiplier.sv
// Directed and sweep bench for booth8_iter_multiplier with a product scoreboard.
module tb_booth8_iter_multiplier;

  localparam int MAXW = 40;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] mant_a;
  logic [10:0] mant_b;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [21:0] product;

  int          checks = 0;
  int          errors = 0;
  logic [21:0] sb_q[$];
  int          hit[9];

  booth8_iter_multiplier dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mant_a   (mant_a),
    .mant_b   (mant_b),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no completion, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one operand pair at a negedge; it is accepted at the following posedge.
  task automatic send(input logic [10:0] a, input logic [10:0] b, input logic m,
                      input logic [21:0] exp);
    int n;
    n = 0;
    while (!in_ready && n < MAXW) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    mant_a   = a;
    mant_b   = b;
    mode     = m;
    in_valid = 1'b1;
    @(posedge clk);
    sb_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    mant_a   = 11'($urandom);
    mant_b   = 11'($urandom);
    mode     = 1'($urandom);
  endtask

  // Count edges after acceptance until out_valid shows (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < MAXW) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic finish_txn(input string tag, input int exp_lat, input int n);
    logic [21:0] e;
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 22'bx;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_product"}, 32'(product), 32'(e));
    chk({tag, "_acc_hi"}, 32'(dut.acc_q[25:22]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid_fall"}, 32'(out_valid), 32'd0);
  endtask

  task automatic txn(input string tag, input logic [10:0] a, input logic [10:0] b,
                     input logic m, input logic [21:0] exp, input int exp_lat);
    int n;
    send(a, b, m, exp);
    wait_valid(n);
    finish_txn(tag, exp_lat, n);
  endtask

  task automatic cover_digits(input logic [10:0] b);
    logic [12:0] be;
    int v;
    be = {1'b0, b, 1'b0};
    for (int i = 0; i < 4; i++) begin
      v = -4 * int'(be[3*i+3]) + 2 * int'(be[3*i+2]) + int'(be[3*i+1]) + int'(be[3*i]);
      hit[v+4]++;
    end
  endtask

  initial begin
    int n;
    int seen;
    int covered;
    logic [10:0] ra;
    logic [10:0] rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    mant_a    = '0;
    mant_b    = '0;
    mode      = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) hit[i] = 0;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);

    // Directed FP16 / INT8 and BF16 cases
    txn("fp16_max", 11'h7FF, 11'h7FF, 1'b0, 22'h3FF001, 4);
    txn("fp16_pow2", 11'h400, 11'h400, 1'b0, 22'h100000, 4);
    txn("fp16_zero", 11'h5A5, 11'h000, 1'b0, 22'h000000, 4);
    txn("bf16_max", 11'h7FF, 11'h7FF, 1'b1, 22'h00FE01, 3);
    txn("bf16_6000", 11'h080, 11'h0C0, 1'b1, 22'h006000, 3);

    // Random BF16 with junk in the ignored upper bits
    for (int i = 0; i < 20; i++) begin
      ra = 11'($urandom);
      rb = 11'($urandom);
      txn("bf16_rand", ra, rb, 1'b1, {14'b0, ra[7:0]} * {14'b0, rb[7:0]}, 3);
    end

    // Backpressure, then in_valid concurrent with the output handshake
    out_ready = 1'b0;
    send(11'h123, 11'h456, 1'b0, {11'b0, 11'h123} * {11'b0, 11'h456});
    wait_valid(n);
    chk("bp_latency", n, 4);
    in_valid = 1'b1;
    mant_a   = 11'd9;
    mant_b   = 11'd7;
    mode     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_product", 32'(product), (sb_q.size() > 0) ? 32'(sb_q[0]) : 32'hx);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    chk("bp_result", 32'(product), (sb_q.size() > 0) ? 32'(sb_q.pop_front()) : 32'hx);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("hs_valid_fall", 32'(out_valid), 32'd0);
    chk("hs_no_same_cycle_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    sb_q.push_back(22'd63);
    @(negedge clk);
    chk("hs_accept_next_cycle", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_valid(n);
    finish_txn("hs_txn", 4, n);

    // Reset two cycles after acceptance aborts the transaction
    send(11'h7FF, 11'h7FF, 1'b0, 22'h3FF001);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    void'(sb_q.pop_back());
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_product", 32'(product), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("abort_no_output", seen, 0);
    txn("after_abort", 11'd3, 11'd5, 1'b0, 22'd15, 4);

    // Full multiplier sweep for two multiplicands
    for (int b = 0; b < 2048; b++) begin
      cover_digits(11'(b));
      txn("sweep_7ff", 11'h7FF, 11'(b), 1'b0, 22'(32'h7FF * b), 4);
    end
    for (int b = 0; b < 2048; b++) begin
      txn("sweep_401", 11'h401, 11'(b), 1'b0, 22'(32'h401 * b), 4);
    end
    covered = 0;
    for (int i = 0; i < 9; i++) if (hit[i] > 0) covered++;
    $display("Booth digit values exercised in sweep: %0d of 9", covered);

    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
